// File: rtl/divider32_multicycle.sv
// Sequential radix-2 restoring divider for MIPS DIV/DIVU: quotient to LO, remainder to HI.
// Produces one quotient bit per clock. Results appear WIDTH+1 edges after the start edge.
module divider32_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_shift;
  logic [WIDTH-1:0] partial_rem;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] dividend_raw;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;

  always_comb begin
    shifted = {partial_rem, dividend_shift[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, divisor_mag};
    // A non-negative difference is always below divisor_mag, so both top bits are clear.
    fits    = (trial[WIDTH+1:WIDTH] == 2'b00);
    dividend_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_abs  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      dividend_neg   <= 1'b0;
      divisor_neg    <= 1'b0;
      dividend_shift <= '0;
      partial_rem    <= '0;
      divisor_mag    <= '0;
      dividend_raw   <= '0;
      done           <= 1'b0;
      div_by_zero    <= 1'b0;
      quotient       <= '0;
      remainder      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend_neg   <= is_signed & dividend[WIDTH-1];
            divisor_neg    <= is_signed & divisor[WIDTH-1];
            dividend_shift <= dividend_abs;
            divisor_mag    <= divisor_abs;
            dividend_raw   <= dividend;
            partial_rem    <= '0;
            count          <= '0;
            div_by_zero    <= (divisor == '0);
            state          <= RUN;
          end
        end
        RUN: begin
          partial_rem    <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          dividend_shift <= {dividend_shift[WIDTH-2:0], fits};
          count          <= count + 1'b1;
          if (count == LAST) state <= FIN;
        end
        FIN: begin
          // Divide-by-zero bypasses sign fixup and returns the untouched dividend.
          if (div_by_zero) begin
            quotient  <= '1;
            remainder <= dividend_raw;
          end else begin
            quotient  <= (dividend_neg ^ divisor_neg) ? -dividend_shift : dividend_shift;
            remainder <= dividend_neg ? -partial_rem : partial_rem;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
